led_bar_gauge: RTL and testbench
================================

# led_bar_gauge

Parametrised LED bar-graph gauge. It holds a level register of 0..N_LED and drives a thermometer-coded LED bar from it. On each internal prescaler tick it either drains (discharge) or fills (charge) the bar. It sits between the game/clock control logic and the board LED pins. It generalises the fixed 13-LED discharge bar with selectable width, tick rate, direction, anchoring, pause/hold, explicit restart and terminal-event pulse.

## Interface
- N_LED, 13, number of LEDs in the bar; must be ≥ 1
- TICK_DIV, 25_000_000, CLOCK cycles per level step; must be ≥ 1 (1 = step every cycle)
- ANCHOR_LSB, 1, 1: lit LEDs occupy LED[level-1:0], so discharge extinguishes the MSB end first; 0: lit LEDs occupy LED[N_LED-1:N_LED-level]
- LW (localparam), $clog2(N_LED+1), level width
- CLOCK  in  1  system clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- run  in  1  1: prescaler advances and level steps on ticks; 0: pause, everything held
- mode  in  1  0: discharge (level decrements), 1: charge (level increments)
- restart  in  1  reload level to start value for current mode, clear prescaler
- LED  out  N_LED  thermometer bar
- level  out  LW  current level, 0..N_LED
- empty  out  1  level == 0
- full  out  1  level == N_LED
- done  out  1  one-cycle pulse when level reaches terminal value by stepping

## Operation
- State: prescaler pcnt (0..TICK_DIV-1), level register lvl (0..N_LED), done register.
- Reset values: lvl = N_LED (bar fully lit), pcnt = 0, done = 0. Outputs at reset: LED all ones, level = N_LED, full = 1, empty = 0, done = 0.
- Per-edge priority is RESET > restart > run.
- restart = 1:
  - lvl loads N_LED if mode = 0, or 0 if mode = 1.
  - pcnt clears to 0 and done = 0.
  - run is ignored that cycle.
- run = 1, no restart:
  - pcnt increments.
  - When pcnt == TICK_DIV-1, the cycle is a tick and pcnt wraps to 0.
- On a tick:
  - mode 0: lvl = lvl-1, saturating at 0.
  - mode 1: lvl = lvl+1, saturating at N_LED.
- run = 0: pcnt, lvl and done (forced 0) are held. Pausing does not lose partial prescaler progress.
- done is set for exactly one cycle, on the tick that moves lvl from 1→0 (mode 0) or N_LED-1→N_LED (mode 1). A tick at an already-saturated level produces no done and no change.
- A mode change mid-run keeps lvl and pcnt. The new direction applies from the next tick.
- LED, level, empty and full are combinational decodes of lvl, with no extra register stage. LED has exactly lvl bits set, at the end chosen by ANCHOR_LSB.
- Arithmetic:
  - pcnt width is $clog2(TICK_DIV), minimum 1.
  - lvl never leaves 0..N_LED; no wrap-around in either direction.

## Timing
- Outputs reflect the new lvl in the same cycle the register updates, i.e. one edge after the tick condition.
- From restart deasserting with run = 1 continuously, the first step takes effect on the TICK_DIV-th rising edge.
- A full drain N_LED→0 completes on edge N_LED·TICK_DIV, and done is high in the following cycle.
- Pausing for P cycles delays all subsequent steps by exactly P cycles.
- restart and RESET take effect on the next rising edge and override a coincident tick.

## Test plan
Benches use N_LED=13, TICK_DIV=4 unless stated.
1. Reset then run=1, mode=0 held:
   - LED steps 0x1FFF → 0x0FFF → … → 0x0000, one step every 4 cycles.
   - done pulses once at the 52nd edge, and empty=1 thereafter.
   - No further change or done pulse.
2. restart with mode=1, then run=1:
   - level goes 0 → 13 in 13 steps and full=1.
   - done pulses once; LED ends at 0x1FFF.
3. Pause: run=1 for 6 cycles, run=0 for 10, then run=1:
   - Second decrement lands 10 cycles later than it would without the pause.
   - level is unchanged during the pause.
4. Mode flip at level 5 (mode 0→1): the next tick gives level 6, with no done pulse.
5. restart and RESET asserted on a tick edge:
   - restart wins and level = 13, with no decrement.
   - RESET mid-drain gives level = 13, done = 0 and pcnt = 0.
6. ANCHOR_LSB=0, N_LED=4, TICK_DIV=1, mode=0:
   - LED goes 1111 → 1110 → 1100 → 1000 → 0000 on consecutive cycles.
   - Repeat with ANCHOR_LSB=1: LED goes 1111 → 0111 → 0011 → 0001 → 0000.

Source files
------------

// File: rtl/led_bar_gauge.sv
// Thermometer-coded LED bar gauge. A prescaler paces a saturating level register
// that drains (mode 0) or fills (mode 1); the bar, flags and level decode combinationally.
module led_bar_gauge #(
    parameter int N_LED      = 13,
    parameter int TICK_DIV   = 25_000_000,
    parameter bit ANCHOR_LSB = 1'b1
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         run,
    input  logic                         mode,
    input  logic                         restart,
    output logic [N_LED-1:0]             LED,
    output logic [$clog2(N_LED+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         done
);

    localparam int LW = $clog2(N_LED + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [LW-1:0] LVL_MAX  = LW'(N_LED);
    localparam logic [PW-1:0] PCNT_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [LW-1:0] lvl;
    logic          done_q;
    logic          tick;

    assign tick = run && (pcnt == PCNT_TOP);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            lvl    <= LVL_MAX;
            pcnt   <= '0;
            done_q <= 1'b0;
        end else if (restart) begin
            lvl    <= mode ? '0 : LVL_MAX;
            pcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            // done is a single-cycle pulse, so it falls back to 0 unless this is a terminal step
            done_q <= 1'b0;
            if (run) begin
                if (tick) begin
                    pcnt <= '0;
                    if (!mode && lvl != '0) begin
                        lvl    <= lvl - LW'(1);
                        done_q <= (lvl == LW'(1));
                    end else if (mode && lvl != LVL_MAX) begin
                        lvl    <= lvl + LW'(1);
                        done_q <= (lvl == LVL_MAX - LW'(1));
                    end
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end

    // NOTE: LED gets a full default before the loop so no bit can infer a latch.
    always_comb begin
        LED = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (ANCHOR_LSB) begin
                LED[i] = (i < int'(lvl));
            end else begin
                LED[N_LED-1-i] = (i < int'(lvl));
            end
        end
    end

    assign level = lvl;
    assign empty = (lvl == '0);
    assign full  = (lvl == LVL_MAX);
    assign done  = done_q;

endmodule

// File: tb/tb_led_bar_gauge.sv
// Directed bench for led_bar_gauge: expectations are queued when stimulus is applied
// and popped for comparison one edge later, when the DUT has produced the result.
module tb_led_bar_gauge;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        run = 1'b0;
    logic        mode = 1'b0;
    logic        restart = 1'b0;

    logic [12:0] LED;
    logic [3:0]  level;
    logic        empty, full, done;

    logic [3:0]  led_msb, led_lsb;
    logic [2:0]  level_msb, level_lsb;
    logic        empty_msb, full_msb, done_msb;
    logic        empty_lsb, full_lsb, done_lsb;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string tag;
        int    lvl;
        bit    dn;
    } exp_t;

    typedef struct {
        string      tag;
        logic [3:0] led_m;
        logic [3:0] led_l;
        int         lvl;
        bit         dn;
    } exp_small_t;

    exp_t       sb[$];
    exp_small_t sb_small[$];

    led_bar_gauge #(.N_LED(13), .TICK_DIV(4), .ANCHOR_LSB(1'b1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .run(run), .mode(mode), .restart(restart),
        .LED(LED), .level(level), .empty(empty), .full(full), .done(done)
    );

    led_bar_gauge #(.N_LED(4), .TICK_DIV(1), .ANCHOR_LSB(1'b0)) u_msb (
        .CLOCK(CLOCK), .RESET(RESET), .run(run), .mode(mode), .restart(restart),
        .LED(led_msb), .level(level_msb), .empty(empty_msb), .full(full_msb), .done(done_msb)
    );

    led_bar_gauge #(.N_LED(4), .TICK_DIV(1), .ANCHOR_LSB(1'b1)) u_lsb (
        .CLOCK(CLOCK), .RESET(RESET), .run(run), .mode(mode), .restart(restart),
        .LED(led_lsb), .level(level_lsb), .empty(empty_lsb), .full(full_lsb), .done(done_lsb)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected state after the coming edge, advance, then pop and compare.
    task automatic expect_edge(input string tag, input int lvl, input bit dn);
        exp_t e;
        logic [31:0] exp_led;
        sb.push_back('{tag, lvl, dn});
        @(posedge CLOCK);
        #1;
        e = sb.pop_front();
        exp_led = (32'd1 << e.lvl) - 32'd1;
        check({e.tag, " level"}, 32'(level), 32'(e.lvl));
        check({e.tag, " LED"},   32'(LED),   exp_led);
        check({e.tag, " empty"}, 32'(empty), 32'(e.lvl == 0));
        check({e.tag, " full"},  32'(full),  32'(e.lvl == 13));
        check({e.tag, " done"},  32'(done),  32'(e.dn));
    endtask

    task automatic expect_small(input string tag, input logic [3:0] led_m,
                                input logic [3:0] led_l, input int lvl, input bit dn);
        exp_small_t e;
        sb_small.push_back('{tag, led_m, led_l, lvl, dn});
        @(posedge CLOCK);
        #1;
        e = sb_small.pop_front();
        check({e.tag, " msb LED"},   32'(led_msb),   32'(e.led_m));
        check({e.tag, " lsb LED"},   32'(led_lsb),   32'(e.led_l));
        check({e.tag, " msb level"}, 32'(level_msb), 32'(e.lvl));
        check({e.tag, " lsb empty"}, 32'(empty_lsb), 32'(e.lvl == 0));
        check({e.tag, " msb done"},  32'(done_msb),  32'(e.dn));
        check({e.tag, " lsb done"},  32'(done_lsb),  32'(e.dn));
    endtask

    initial begin
        int r;
        logic [3:0] msb_seq [5];
        logic [3:0] lsb_seq [5];

        // Reset state
        expect_edge("reset0", 13, 1'b0);
        expect_edge("reset1", 13, 1'b0);

        // 1: drain from reset, one step per 4 edges, done after edge 52
        RESET = 1'b0;
        run   = 1'b1;
        mode  = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            expect_edge($sformatf("drain e%0d", k), (13 - k / 4 < 0) ? 0 : 13 - k / 4, k == 52);
        end

        // 2: restart in charge mode, then fill to 13
        restart = 1'b1;
        mode    = 1'b1;
        expect_edge("charge restart", 0, 1'b0);
        restart = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            expect_edge($sformatf("charge e%0d", k), (k / 4 > 13) ? 13 : k / 4, k == 52);
        end

        // 3: pause for 10 edges after 6 running edges
        restart = 1'b1;
        mode    = 1'b0;
        expect_edge("pause restart", 13, 1'b0);
        restart = 1'b0;
        r = 0;
        for (int e = 1; e <= 26; e++) begin
            run = !(e > 6 && e <= 16);
            if (run) r++;
            expect_edge($sformatf("pause e%0d", e), 13 - r / 4, 1'b0);
        end
        run = 1'b1;

        // 4: flip to charge at level 5
        restart = 1'b1;
        expect_edge("flip restart", 13, 1'b0);
        restart = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            expect_edge($sformatf("flip dn e%0d", e), 13 - e / 4, 1'b0);
        end
        mode = 1'b1;
        for (int e = 33; e <= 40; e++) begin
            expect_edge($sformatf("flip up e%0d", e), 5 + (e - 32) / 4, 1'b0);
        end

        // 5a: restart coincident with a tick wins and clears the prescaler
        mode    = 1'b0;
        restart = 1'b1;
        expect_edge("ovr restart", 13, 1'b0);
        restart = 1'b0;
        for (int e = 1; e <= 3; e++) expect_edge($sformatf("ovr pre e%0d", e), 13, 1'b0);
        restart = 1'b1;
        expect_edge("ovr restart on tick", 13, 1'b0);
        restart = 1'b0;
        for (int e = 1; e <= 4; e++) expect_edge($sformatf("ovr post e%0d", e), (e == 4) ? 12 : 13, 1'b0);

        // 5b: RESET on the tick that would have produced done
        restart = 1'b1;
        expect_edge("rst restart", 13, 1'b0);
        restart = 1'b0;
        for (int e = 1; e <= 51; e++) expect_edge($sformatf("rst drain e%0d", e), 13 - e / 4, 1'b0);
        RESET = 1'b1;
        expect_edge("rst on terminal tick", 13, 1'b0);
        RESET = 1'b0;
        for (int e = 1; e <= 4; e++) expect_edge($sformatf("rst post e%0d", e), (e == 4) ? 12 : 13, 1'b0);

        // 6: 4-LED bars, step every cycle, both anchorings
        msb_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        lsb_seq = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        mode    = 1'b0;
        restart = 1'b1;
        expect_small("bar4 restart", msb_seq[0], lsb_seq[0], 4, 1'b0);
        restart = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            expect_small($sformatf("bar4 e%0d", e), msb_seq[e], lsb_seq[e], 4 - e, e == 4);
        end
        expect_small("bar4 hold", 4'b0000, 4'b0000, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
